crc16_frame_tx: RTL and testbench
=================================

// Module: crc16_frame_tx
// PURPOSE
//  Transmit-side framer for 16-bit word streams. It accepts words from the upstream source
//  over a valid/ready handshake and passes them downstream through a one-word output register.
//  On every accepted word it updates a running CRC-16 (1+x^5+x^12+x^16) and appends the
//  final CRC as an extra word after the frame's last word. It sits between the packet source
//  and the SSD link/flash write path; receivers re-run the same CRC over data+CRC, expect 0.
// PARAMETERS
//  MAX_WORDS  256  max data words per frame; reaching it without in_last forces frame close
//  CNT_W      16   width of frame_cnt
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst_n      in   1      reset, asynchronous, active-low
//  in_valid   in   1      upstream word valid
//  in_ready   out  1      block can accept word this cycle
//  in_data    in   16     upstream data word
//  in_last    in   1      word is last of frame
//  out_valid  out  1      output register holds a word
//  out_ready  in   1      downstream accepts word
//  out_data   out  16     data word or appended CRC
//  out_last   out  1      high only with CRC word (end of frame)
//  out_is_crc out  1      out_data is the CRC word
//  frame_cnt  out  CNT_W  frames completed (CRC word loaded), wraps 2^CNT_W-1 -> 0
//  err_len    out  1      sticky: a frame hit MAX_WORDS without in_last
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=S_IDLE, crc=16'hFFFF, word_cnt=0, out_valid=0, out_data=0,
//    out_last=0, out_is_crc=0, frame_cnt=0, err_len=0. Takes effect mid-frame: partial frame
//    discarded, nothing of it emitted afterwards.
//  - CRC update per accepted word: x = crc ^ in_data; crc_next = 16 MSB-first shifts of x:
//    repeat 16 { x = {x[14:0],1'b0} ^ (x[15] ? 16'h1021 : 0) }. No reflection, no final XOR.
//    Equivalent to CRC-16/CCITT-FALSE over bytes sent high byte first.
//  - space = !out_valid || out_ready (output register free or emptying this cycle).
//  - in_ready = space && (state != S_CRC). Combinational, no dependence on in_valid.
//  - States: S_IDLE (no frame open), S_DATA (frame open), S_CRC (CRC word pending).
//  - Accept (in_valid && in_ready): out_data<=in_data, out_valid<=1, out_last<=0,
//    out_is_crc<=0, crc<=crc_next, word_cnt++. Latency: word appears on out_* 1 cycle later.
//    close = in_last || (word_cnt == MAX_WORDS-1). If close: state<=S_CRC; err_len<=1 if
//    !in_last. Else state<=S_DATA.
//  - S_CRC with space: out_data<=crc (already includes last word), out_valid<=1,
//    out_last<=1, out_is_crc<=1, crc<=16'hFFFF, word_cnt<=0, frame_cnt++, state<=S_IDLE.
//    in_ready is low in this cycle: exactly one input bubble per frame.
//  - No accept and no CRC load while out_ready=1: out_valid<=0 (other out_* hold).
//  - out_valid=1 && out_ready=0: all out_* stable until handshake; in_ready=0.
//  - Throughput: N-word frame emits N+1 words; back-to-back frames sustain N/(N+1).
//  - word_cnt width = clog2(MAX_WORDS+1). Zero-length frames impossible (last rides a word).
//  - err_len is cleared only by reset. frame_cnt wraps silently.
// TESTING
//  1 Single-word frame 0x0000, last=1, out_ready=1 -> out 0x0000 (last=0), then 0x1D0F
//    (last=1, is_crc=1); frame_cnt=1.
//  2 4-word frames with random data, 200 frames, random out_ready -> every CRC word matches the
//    bit-serial model; CRC engine run over data+CRC gives 0x0000; no loss or duplication.
//  3 out_ready=0 for 5 cycles mid-frame -> in_ready=0 for those cycles, out_* held stable,
//    stream resumes in order.
//  4 Back-to-back 3-word frames, in_valid=1 always -> in_ready low exactly 1 cycle per frame;
//    output order D0 D1 D2 CRC D0 ...; crc reseeded to 0xFFFF (frame 2 CRC = standalone value).
//  5 MAX_WORDS=4, 6 words with last only on word 6 -> CRC after word 4, err_len=1; words 5-6
//    form a second frame with its own CRC; frame_cnt=2.
//  6 rst_n low for 1 cycle after 2 words of a frame -> all outputs at reset values at once;
//    next frame 0x0000/last -> CRC 0x1D0F.

Source files
------------

// File: rtl/crc16_frame_tx.sv
// Transmit framer for 16-bit word streams: forwards data words through a one-word
// output register and appends a CRC-16 (poly 0x1021, seed 0xFFFF) word per frame.
module crc16_frame_tx #(
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_last,
  output logic             out_is_crc,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err_len,
  output logic [1:0]       dbg_state
);

  // Handshake: a word moves on either side only in a cycle where valid && ready;
  // in_ready never depends on in_valid, and a presented output word holds until taken.

  localparam int WC_W = $clog2(MAX_WORDS + 1);
  localparam logic [WC_W-1:0] LAST_CNT = WC_W'(MAX_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_CRC  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [15:0]     crc;
  logic [WC_W-1:0] word_cnt;
  logic            space;
  logic            accept;
  logic            close;
  logic            load_crc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] x;
    x = c ^ d;
    for (int i = 0; i < 16; i++) begin
      x = {x[14:0], 1'b0} ^ (x[15] ? 16'h1021 : 16'h0000);
    end
    return x;
  endfunction

  assign space     = !out_valid || out_ready;
  assign in_ready  = space && (state != S_CRC);
  assign accept    = in_valid && in_ready;
  assign close     = in_last || (word_cnt == LAST_CNT);
  assign load_crc  = (state == S_CRC) && space;
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = close ? S_CRC : S_DATA;
    end else if (load_crc) begin
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // accept and load_crc are exclusive: in_ready is low while the CRC word is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc        <= 16'hFFFF;
      word_cnt   <= '0;
      out_valid  <= 1'b0;
      out_data   <= 16'h0000;
      out_last   <= 1'b0;
      out_is_crc <= 1'b0;
      frame_cnt  <= '0;
      err_len    <= 1'b0;
    end else if (accept) begin
      out_data   <= in_data;
      out_valid  <= 1'b1;
      out_last   <= 1'b0;
      out_is_crc <= 1'b0;
      crc        <= crc_step(crc, in_data);
      word_cnt   <= word_cnt + 1'b1;
      if (close && !in_last) begin
        err_len <= 1'b1;
      end
    end else if (load_crc) begin
      out_data   <= crc;
      out_valid  <= 1'b1;
      out_last   <= 1'b1;
      out_is_crc <= 1'b1;
      crc        <= 16'hFFFF;
      word_cnt   <= '0;
      frame_cnt  <= frame_cnt + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crc16_frame_tx.sv
// Bench for crc16_frame_tx (MAX_WORDS=4): single-word vector table, stall, back-to-back,
// random-ready stream, forced length close and mid-frame reset.
module tb_crc16_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_is_crc;
  logic [15:0] frame_cnt;
  logic        err_len;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  int bubbles = 0;
  int rdy_ctl = 1;
  logic [17:0] exp_q[$];
  logic [15:0] rx_crc = 16'hFFFF;
  logic [15:0] fw[8];

  typedef struct {
    logic [15:0] data;
    logic [15:0] crc;
  } vec_t;
  vec_t tbl[7];

  crc16_frame_tx #(.MAX_WORDS(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_is_crc(out_is_crc),
    .frame_cnt(frame_cnt), .err_len(err_len), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Bit-serial reference: one message bit at a time, MSB first.
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_ctl)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard: every output handshake pops one expected {is_crc,last,data} word.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rx_crc = 16'hFFFF;
      end else if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h expected none", {out_is_crc, out_last, out_data});
        end else begin
          e = exp_q.pop_front();
          chk("out_word", {14'd0, out_is_crc, out_last, out_data}, {14'd0, e});
        end
        rx_crc = crc_model(rx_crc, out_data);
        if (out_is_crc) begin
          chk("rx_residue", {16'd0, rx_crc}, 32'd0);
          rx_crc = 16'hFFFF;
        end
      end
    end
  end

  task automatic send_word(input logic [15:0] d, input logic l);
    int t;
    logic acc;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    t = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) bubbles++;
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 1000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got no in_ready expected accept within 1000 cycles");
        break;
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = crc_model(c, fw[i]);
      exp_q.push_back({2'b00, fw[i]});
    end
    exp_q.push_back({2'b11, c});
    exp_frames++;
    for (int i = 0; i < n; i++) send_word(fw[i], i == n - 1);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d words left expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_frame_cnt"}, {16'd0, frame_cnt}, 32'(exp_frames[15:0]));
  endtask

  initial begin
    logic [17:0] cap;
    tbl[0] = '{16'h0000, 16'h1D0F};
    tbl[1] = '{16'hFFFF, 16'h0000};
    tbl[2] = '{16'hFFFE, 16'h1021};
    tbl[3] = '{16'hFFFD, 16'h2042};
    tbl[4] = '{16'hFFFC, 16'h3063};
    tbl[5] = '{16'hFFF7, 16'h8108};
    tbl[6] = '{16'hFFEF, 16'h1231};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_is_crc", out_is_crc, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single-word frames from the vector table
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({2'b00, tbl[i].data});
      exp_q.push_back({2'b11, tbl[i].crc});
      exp_frames++;
      send_word(tbl[i].data, 1'b1);
    end
    idle();
    drain("table");

    // Downstream stall mid-frame
    fw[0] = 16'h1111; fw[1] = 16'h2222; fw[2] = 16'h3333; fw[3] = 16'h4444;
    fork
      begin
        send_frame(4);
        idle();
      end
      begin
        repeat (2) @(posedge clk);
        rdy_ctl = 0;
        @(posedge clk);
        @(negedge clk);
        cap = {out_is_crc, out_last, out_data};
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        repeat (4) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_hold", {14'd0, out_is_crc, out_last, out_data}, {14'd0, cap});
        end
        rdy_ctl = 1;
      end
    join
    drain("stall");

    // Back-to-back 3-word frames; first two identical so reseeding is visible
    bubbles = 0;
    fw[0] = 16'h0001; fw[1] = 16'h0002; fw[2] = 16'h0003;
    send_frame(3);
    send_frame(3);
    fw[0] = 16'hA5A5; fw[1] = 16'h5A5A; fw[2] = 16'hC3C3;
    send_frame(3);
    idle();
    chk("b2b_bubbles", bubbles, 2);
    @(negedge clk);
    chk("b2b_crc_bubble", in_ready, 0);
    @(negedge clk);
    chk("b2b_ready_again", in_ready, 1);
    drain("b2b");

    // 200 random 4-word frames under random out_ready
    rdy_ctl = 2;
    for (int f = 0; f < 200; f++) begin
      for (int i = 0; i < 4; i++) fw[i] = 16'($urandom_range(0, 65535));
      send_frame(4);
    end
    idle();
    drain("random");
    rdy_ctl = 1;
    chk("err_len_before_overrun", err_len, 0);

    // Six words with last only on the sixth: forced close after word 4
    begin
      logic [15:0] ca;
      logic [15:0] cb;
      ca = 16'hFFFF;
      cb = 16'hFFFF;
      for (int i = 0; i < 6; i++) fw[i] = 16'h0100 + 16'(i);
      for (int i = 0; i < 4; i++) begin
        ca = crc_model(ca, fw[i]);
        exp_q.push_back({2'b00, fw[i]});
      end
      exp_q.push_back({2'b11, ca});
      for (int i = 4; i < 6; i++) begin
        cb = crc_model(cb, fw[i]);
        exp_q.push_back({2'b00, fw[i]});
      end
      exp_q.push_back({2'b11, cb});
      exp_frames += 2;
      for (int i = 0; i < 6; i++) send_word(fw[i], i == 5);
      idle();
      drain("overrun");
      chk("err_len_after_overrun", err_len, 1);
    end

    // Reset two words into a frame
    exp_q.push_back({2'b00, 16'hBEEF});
    send_word(16'hBEEF, 1'b0);
    send_word(16'hCAFE, 1'b0);
    rst_n = 1'b0;
    idle();
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_out_is_crc", out_is_crc, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_err_len", err_len, 0);
    chk("mid_rst_state", dbg_state, 0);
    chk("mid_rst_leftover", exp_q.size(), 0);
    exp_q.delete();
    exp_frames = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back({2'b00, 16'h0000});
    exp_q.push_back({2'b11, 16'h1D0F});
    exp_frames++;
    send_word(16'h0000, 1'b1);
    idle();
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
